// File: rtl/acc_alu.sv
// Accumulator ALU: single-cycle arithmetic/logic ops on an internal accumulator,
// plus multi-cycle unsigned shift-add multiply and restoring divide.
module acc_alu #(
    parameter int WIDTH = 16,
    parameter int OPW   = 4
) (
    input  logic             clk,
    input  logic             rst,
    input  logic             op_valid,
    output logic             op_ready,
    input  logic [OPW-1:0]   opcode,
    input  logic [WIDTH-1:0] data_in,
    output logic [WIDTH-1:0] acc_out,
    output logic [WIDTH-1:0] rem_out,
    output logic             busy,
    output logic             done,
    output logic             carry,
    output logic             zero,
    output logic             ovf,
    output logic             err
);

    localparam int CW = $clog2(WIDTH);
    localparam logic [CW-1:0] LAST_STEP = CW'(WIDTH - 1);

    localparam logic [OPW-1:0] OP_NOOP  = 4'b0000;
    localparam logic [OPW-1:0] OP_RESET = 4'b0001;
    localparam logic [OPW-1:0] OP_ADD   = 4'b0010;
    localparam logic [OPW-1:0] OP_SUB   = 4'b0011;
    localparam logic [OPW-1:0] OP_MULT  = 4'b0100;
    localparam logic [OPW-1:0] OP_DIV   = 4'b0101;
    localparam logic [OPW-1:0] OP_AND   = 4'b0110;
    localparam logic [OPW-1:0] OP_OR    = 4'b0111;
    localparam logic [OPW-1:0] OP_NOT   = 4'b1000;
    localparam logic [OPW-1:0] OP_NOR   = 4'b1001;

    typedef enum logic [1:0] {S_IDLE, S_MUL, S_DIV} state_t;

    state_t state_q, state_d;
    logic [WIDTH-1:0] acc_q, acc_d, rem_q, rem_d;
    logic carry_q, carry_d, zero_q, zero_d, ovf_q, ovf_d, err_q, err_d, done_q, done_d;

    // a: multiplicand (shifted left) or divisor; b: multiplier (shifted right)
    // or dividend/quotient (shifted left); p: partial product or remainder.
    logic [2*WIDTH-1:0] a_q, a_d, p_q, p_d;
    logic [WIDTH-1:0]   b_q, b_d;
    logic [CW-1:0]      cnt_q, cnt_d;

    logic [WIDTH:0]     sum_w, r_sh, r_new;
    logic [2*WIDTH-1:0] p_step;
    logic [WIDTH-1:0]   res, q_new;
    logic               wr_acc, r_ge;

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        rem_d   = rem_q;
        carry_d = carry_q;
        zero_d  = zero_q;
        ovf_d   = ovf_q;
        err_d   = err_q;
        done_d  = 1'b0;
        a_d     = a_q;
        b_d     = b_q;
        p_d     = p_q;
        cnt_d   = cnt_q;
        res     = '0;
        wr_acc  = 1'b0;
        sum_w   = {1'b0, acc_q} + {1'b0, data_in};
        p_step  = p_q + (b_q[0] ? a_q : '0);
        r_sh    = {p_q[WIDTH-1:0], b_q[WIDTH-1]};
        r_ge    = (r_sh >= {1'b0, a_q[WIDTH-1:0]});
        r_new   = r_ge ? (r_sh - {1'b0, a_q[WIDTH-1:0]}) : r_sh;
        q_new   = {b_q[WIDTH-2:0], r_ge};

        case (state_q)
            S_IDLE: begin
                if (op_valid) begin
                    done_d = 1'b1;
                    err_d  = 1'b0;
                    case (opcode)
                        OP_NOOP: ;
                        OP_RESET: begin
                            acc_d   = '0;
                            rem_d   = '0;
                            carry_d = 1'b0;
                            zero_d  = 1'b0;
                            ovf_d   = 1'b0;
                        end
                        OP_ADD: begin
                            res     = sum_w[WIDTH-1:0];
                            carry_d = sum_w[WIDTH];
                            wr_acc  = 1'b1;
                        end
                        OP_SUB: begin
                            res     = acc_q - data_in;
                            carry_d = (data_in > acc_q);
                            wr_acc  = 1'b1;
                        end
                        OP_AND: begin res = acc_q & data_in;    carry_d = 1'b0; wr_acc = 1'b1; end
                        OP_OR:  begin res = acc_q | data_in;    carry_d = 1'b0; wr_acc = 1'b1; end
                        OP_NOT: begin res = ~acc_q;             carry_d = 1'b0; wr_acc = 1'b1; end
                        OP_NOR: begin res = ~(acc_q | data_in); carry_d = 1'b0; wr_acc = 1'b1; end
                        OP_MULT: begin
                            a_d     = {{WIDTH{1'b0}}, acc_q};
                            b_d     = data_in;
                            p_d     = '0;
                            cnt_d   = '0;
                            done_d  = 1'b0;
                            state_d = S_MUL;
                        end
                        OP_DIV: begin
                            if (data_in == '0) begin
                                err_d   = 1'b1;
                                carry_d = 1'b0;
                                ovf_d   = 1'b0;
                            end else begin
                                a_d     = {{WIDTH{1'b0}}, data_in};
                                b_d     = acc_q;
                                p_d     = '0;
                                cnt_d   = '0;
                                done_d  = 1'b0;
                                state_d = S_DIV;
                            end
                        end
                        default: err_d = 1'b1;
                    endcase
                    if (wr_acc) begin
                        acc_d  = res;
                        zero_d = (res == '0);
                        ovf_d  = 1'b0;
                    end
                end
            end
            S_MUL: begin
                p_d   = p_step;
                a_d   = {a_q[2*WIDTH-2:0], 1'b0};
                b_d   = {1'b0, b_q[WIDTH-1:1]};
                cnt_d = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    acc_d   = p_step[WIDTH-1:0];
                    ovf_d   = |p_step[2*WIDTH-1:WIDTH];
                    zero_d  = (p_step[WIDTH-1:0] == '0);
                    carry_d = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            S_DIV: begin
                p_d          = '0;
                p_d[WIDTH:0] = r_new;
                b_d          = q_new;
                cnt_d        = cnt_q + 1'b1;
                if (cnt_q == LAST_STEP) begin
                    acc_d   = q_new;
                    rem_d   = r_new[WIDTH-1:0];
                    zero_d  = (q_new == '0);
                    carry_d = 1'b0;
                    ovf_d   = 1'b0;
                    done_d  = 1'b1;
                    state_d = S_IDLE;
                end
            end
            default: state_d = S_IDLE;
        endcase
    end

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            rem_q   <= '0;
            carry_q <= 1'b0;
            zero_q  <= 1'b0;
            ovf_q   <= 1'b0;
            err_q   <= 1'b0;
            done_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            rem_q   <= rem_d;
            carry_q <= carry_d;
            zero_q  <= zero_d;
            ovf_q   <= ovf_d;
            err_q   <= err_d;
            done_q  <= done_d;
        end
    end

    // Iteration datapath needs no reset; it is always reloaded on accept.
    always_ff @(posedge clk) begin
        a_q   <= a_d;
        b_q   <= b_d;
        p_q   <= p_d;
        cnt_q <= cnt_d;
    end

    assign op_ready = (state_q == S_IDLE);
    assign busy     = (state_q != S_IDLE);
    assign acc_out  = acc_q;
    assign rem_out  = rem_q;
    assign carry    = carry_q;
    assign zero     = zero_q;
    assign ovf      = ovf_q;
    assign err      = err_q;
    assign done     = done_q;

endmodule

// File: tb/tb_acc_alu.sv
// Bench for acc_alu: directed spec vectors plus random ops against an
// arithmetic reference model of the accumulator and flags.
module tb_acc_alu;

    localparam int W = 16;

    logic          clk = 1'b0;
    logic          rst = 1'b1;
    logic          op_valid = 1'b0;
    logic          op_ready;
    logic [3:0]    opcode = 4'd0;
    logic [W-1:0]  data_in = '0;
    logic [W-1:0]  acc_out, rem_out;
    logic          busy, done, carry, zero, ovf, err;

    int n_tests = 0;
    int n_fail  = 0;

    logic [W-1:0] m_acc = '0, m_rem = '0;
    logic m_c = 1'b0, m_z = 1'b0, m_o = 1'b0, m_e = 1'b0;

    acc_alu #(.WIDTH(W), .OPW(4)) dut (
        .clk(clk), .rst(rst), .op_valid(op_valid), .op_ready(op_ready),
        .opcode(opcode), .data_in(data_in), .acc_out(acc_out), .rem_out(rem_out),
        .busy(busy), .done(done), .carry(carry), .zero(zero), .ovf(ovf), .err(err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        n_tests++;
        assert (obs === exp) else begin
            n_fail++;
            $error("FAIL %s observed=%0h expected=%0h", tag, obs, exp);
        end
    endtask

    task automatic check_state(input string tag);
        check({tag, ".acc"},   32'(acc_out), 32'(m_acc));
        check({tag, ".rem"},   32'(rem_out), 32'(m_rem));
        check({tag, ".carry"}, 32'(carry),   32'(m_c));
        check({tag, ".zero"},  32'(zero),    32'(m_z));
        check({tag, ".ovf"},   32'(ovf),     32'(m_o));
        check({tag, ".err"},   32'(err),     32'(m_e));
    endtask

    // Issue one op; if hold is set, keep op_valid asserted with junk while busy.
    task automatic do_op(input logic [3:0] op, input logic [W-1:0] d, input bit hold, input string tag);
        logic [W-1:0] pre_acc;
        longint unsigned prod;
        int s;
        bit multi;
        pre_acc = m_acc;
        multi = 1'b0;
        case (op)
            4'd0: m_e = 1'b0;
            4'd1: begin m_acc = '0; m_rem = '0; m_c = 0; m_z = 0; m_o = 0; m_e = 0; end
            4'd2: begin s = int'(m_acc) + int'(d); m_c = (s >= 65536); m_acc = W'(s); end
            4'd3: begin m_c = (d > m_acc); m_acc = m_acc - d; end
            4'd4: begin
                prod = longint'(m_acc) * longint'(d);
                m_acc = W'(prod); m_o = (prod >= 65536); m_c = 0; multi = 1'b1;
            end
            4'd5: begin
                if (d == 0) begin m_e = 1'b1; m_c = 0; m_o = 0; end
                else begin m_rem = m_acc % d; m_acc = m_acc / d; m_c = 0; m_o = 0; multi = 1'b1; end
            end
            4'd6: begin m_acc = m_acc & d;    m_c = 0; end
            4'd7: begin m_acc = m_acc | d;    m_c = 0; end
            4'd8: begin m_acc = ~m_acc;       m_c = 0; end
            4'd9: begin m_acc = ~(m_acc | d); m_c = 0; end
            default: m_e = 1'b1;
        endcase
        if (op >= 4'd2 && op <= 4'd9 && !(op == 4'd5 && d == 0)) begin
            m_z = (m_acc == 0);
            if (op != 4'd4) m_o = 1'b0;
            m_e = 1'b0;
        end
        @(negedge clk);
        op_valid = 1'b1; opcode = op; data_in = d;
        @(negedge clk);
        if (multi) begin
            for (int i = 0; i < W; i++) begin
                check({tag, ".busy"},     32'(busy),    32'd1);
                check({tag, ".acc_hold"}, 32'(acc_out), 32'(pre_acc));
                check({tag, ".no_done"},  32'(done),    32'd0);
                if (hold) begin
                    op_valid = 1'b1; opcode = 4'($urandom); data_in = W'($urandom);
                end else begin
                    op_valid = 1'b0;
                end
                @(negedge clk);
            end
        end
        op_valid = 1'b0;
        check({tag, ".done"},  32'(done),     32'd1);
        check({tag, ".idle"},  32'(busy),     32'd0);
        check({tag, ".ready"}, 32'(op_ready), 32'd1);
        check_state(tag);
        @(negedge clk);
        check({tag, ".done_once"}, 32'(done), 32'd0);
    endtask

    initial begin
        logic [3:0]   rop;
        logic [W-1:0] rd;
        // reset
        repeat (2) @(posedge clk);
        @(negedge clk);
        rst = 1'b0;
        check("rst.busy", 32'(busy), 32'd0);
        check("rst.done", 32'(done), 32'd0);
        check("rst.ready", 32'(op_ready), 32'd1);
        check_state("rst");

        do_op(4'd2, 16'hFFFF, 1'b0, "add1");
        do_op(4'd2, 16'h0001, 1'b0, "add2");
        check("add_wrap.acc", 32'(acc_out), 32'h0);
        check("add_wrap.carry", 32'(carry), 32'd1);
        check("add_wrap.zero", 32'(zero), 32'd1);

        do_op(4'd1, 16'h0000, 1'b0, "clr1");
        do_op(4'd2, 16'h0005, 1'b0, "ld5");
        do_op(4'd3, 16'h0007, 1'b0, "sub");
        check("sub.acc", 32'(acc_out), 32'hFFFE);
        check("sub.carry", 32'(carry), 32'd1);

        do_op(4'd1, 16'h0000, 1'b0, "clr2");
        do_op(4'd2, 16'h0300, 1'b0, "ld300");
        do_op(4'd4, 16'h0100, 1'b1, "mult");
        check("mult.ovf", 32'(ovf), 32'd1);
        check("mult.zero", 32'(zero), 32'd1);

        do_op(4'd1, 16'h0000, 1'b0, "clr3");
        do_op(4'd2, 16'h0064, 1'b0, "ld100");
        do_op(4'd5, 16'h0007, 1'b0, "div");
        check("div.acc", 32'(acc_out), 32'h000E);
        check("div.rem", 32'(rem_out), 32'h0002);
        do_op(4'd5, 16'h0000, 1'b0, "div0");
        check("div0.err", 32'(err), 32'd1);

        do_op(4'd1, 16'h0000, 1'b0, "clr4");
        do_op(4'd2, 16'h0F0F, 1'b0, "ld0f0f");
        do_op(4'd15, 16'h1234, 1'b0, "illegal");
        check("illegal.err", 32'(err), 32'd1);
        do_op(4'd6, 16'h00FF, 1'b0, "and");
        check("and.acc", 32'(acc_out), 32'h000F);
        check("and.err", 32'(err), 32'd0);

        // abort a MULT with rst part-way through
        @(negedge clk);
        op_valid = 1'b1; opcode = 4'd4; data_in = 16'h0003;
        @(negedge clk);
        repeat (4) begin
            check("abort.busy", 32'(busy), 32'd1);
            @(negedge clk);
        end
        rst = 1'b1;
        @(negedge clk);
        rst = 1'b0; op_valid = 1'b0;
        m_acc = '0; m_rem = '0; m_c = 0; m_z = 0; m_o = 0; m_e = 0;
        check("abort.busy0", 32'(busy), 32'd0);
        check_state("abort");
        for (int i = 0; i < W + 2; i++) begin
            check("abort.no_done", 32'(done), 32'd0);
            @(negedge clk);
        end

        // random ops against the model
        for (int i = 0; i < 60; i++) begin
            rop = 4'($urandom_range(0, 15));
            case ($urandom_range(0, 7))
                0: rd = '0;
                1: rd = '1;
                default: rd = W'($urandom);
            endcase
            do_op(rop, rd, 1'($urandom), "rnd");
        end

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
